// File: rtl/code_lock_fsm.sv
// Keypad code-lock controller: the clocked neighbour of an external 4-bit
// equality comparator. It feeds the comparator one digit pair per key press,
// collects the EQ result, and runs the unlock / failure / lockout sequencing.
module code_lock_fsm #(
    parameter int unsigned             DIGITS      = 4,
    parameter logic [4*DIGITS-1:0]     CODE        = 16'h2025,
    parameter int unsigned             MAX_FAIL    = 3,
    parameter int unsigned             OPEN_CYCLES = 8,
    parameter int unsigned             LOCK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_data,
    input  logic       key_clear,
    output logic [3:0] cmp_a,
    output logic [3:0] cmp_b,
    input  logic       cmp_eq,
    output logic [2:0] digit_idx,
    output logic       unlock,
    output logic       fail,
    output logic       alarm,
    output logic [1:0] fail_cnt
);

    localparam int unsigned TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_OPEN,
        S_LOCKOUT
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      digit_idx_q, digit_idx_d;
    logic            mismatch_q, mismatch_d;
    logic [1:0]      fail_cnt_q, fail_cnt_d;
    logic            fail_q, fail_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            final_ok;
    int unsigned     next_fail;

    // Comparator operands: entered digit and the stored digit at the current position.
    always_comb begin
        cmp_a = key_data;
        cmp_b = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (32'(digit_idx_q) == i) begin
                cmp_b = CODE[4*(DIGITS-1-i) +: 4];
            end
        end
    end

    // Next-state logic: key collection, entry evaluation and the OPEN/LOCKOUT timers.
    // The timer is loaded with N-1 on entry so the state lasts exactly N cycles.
    always_comb begin
        state_d     = state_q;
        digit_idx_d = digit_idx_q;
        mismatch_d  = mismatch_q;
        fail_cnt_d  = fail_cnt_q;
        fail_d      = 1'b0;
        timer_d     = timer_q;
        final_ok    = 1'b0;
        next_fail   = 32'(fail_cnt_q) + 1;
        unique case (state_q)
            S_OPEN, S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                    if (state_q == S_LOCKOUT) begin
                        fail_cnt_d = '0;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                if (key_clear) begin
                    state_d     = S_IDLE;
                    digit_idx_d = '0;
                    mismatch_d  = 1'b0;
                end else if (key_valid) begin
                    if (32'(digit_idx_q) < DIGITS - 1) begin
                        state_d     = S_ENTRY;
                        digit_idx_d = digit_idx_q + 3'd1;
                        mismatch_d  = mismatch_q | ~cmp_eq;
                    end else begin
                        final_ok    = ~(mismatch_q | ~cmp_eq);
                        digit_idx_d = '0;
                        mismatch_d  = 1'b0;
                        if (final_ok) begin
                            state_d    = S_OPEN;
                            timer_d    = TW'(OPEN_CYCLES - 1);
                            fail_cnt_d = '0;
                        end else begin
                            fail_d = 1'b1;
                            if (next_fail >= MAX_FAIL) begin
                                state_d    = S_LOCKOUT;
                                timer_d    = TW'(LOCK_CYCLES - 1);
                                fail_cnt_d = 2'(MAX_FAIL);
                            end else begin
                                state_d    = S_IDLE;
                                fail_cnt_d = 2'(next_fail);
                            end
                        end
                    end
                end
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            digit_idx_q <= '0;
            mismatch_q  <= 1'b0;
            fail_cnt_q  <= '0;
            fail_q      <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            digit_idx_q <= digit_idx_d;
            mismatch_q  <= mismatch_d;
            fail_cnt_q  <= fail_cnt_d;
            fail_q      <= fail_d;
            timer_q     <= timer_d;
        end
    end

    assign digit_idx = digit_idx_q;
    assign fail_cnt  = fail_cnt_q;
    assign fail      = fail_q;
    assign unlock    = (state_q == S_OPEN);
    assign alarm     = (state_q == S_LOCKOUT);

endmodule

// File: tb/tb_code_lock_fsm.sv
// Scoreboard bench for code_lock_fsm: the driver updates a behavioural lock model
// per clock and queues the expected outputs; a monitor compares on each falling edge.
module tb_code_lock_fsm;

    localparam int DIGITS      = 4;
    localparam int MAX_FAIL    = 3;
    localparam int OPEN_CYCLES = 8;
    localparam int LOCK_CYCLES = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_data = '0;
    logic       key_clear = 1'b0;
    logic [3:0] cmp_a, cmp_b;
    logic       cmp_eq;
    logic [2:0] digit_idx;
    logic       unlock, fail, alarm;
    logic [1:0] fail_cnt;

    code_lock_fsm #(
        .DIGITS(DIGITS), .CODE(16'h2025), .MAX_FAIL(MAX_FAIL),
        .OPEN_CYCLES(OPEN_CYCLES), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_data(key_data),
        .key_clear(key_clear), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_eq(cmp_eq),
        .digit_idx(digit_idx), .unlock(unlock), .fail(fail), .alarm(alarm),
        .fail_cnt(fail_cnt)
    );

    // The external comparator.
    assign cmp_eq = (cmp_a == cmp_b);

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int unl;
        int fl;
        int alm;
        int fcnt;
        int cb;
    } exp_t;

    exp_t exp_q[$];
    int   code_d[DIGITS] = '{2, 0, 2, 5};
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: entered digits kept as a list, timers as remaining cycles.
    int   m_digits[$];
    int   m_fail = 0;
    int   m_open = 0;
    int   m_lock = 0;
    int   m_pulse = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    task automatic model(input bit r, input bit kv, input int kd, input bit kc);
        bit ok;
        m_pulse = 0;
        if (r) begin
            m_digits.delete();
            m_fail = 0; m_open = 0; m_lock = 0;
        end else if (m_open > 0) begin
            m_open--;
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_fail = 0;
        end else if (kc) begin
            m_digits.delete();
        end else if (kv) begin
            m_digits.push_back(kd);
            if (m_digits.size() == DIGITS) begin
                ok = 1;
                for (int i = 0; i < DIGITS; i++)
                    if (m_digits[i] != code_d[i]) ok = 0;
                m_digits.delete();
                if (ok) begin
                    m_open = OPEN_CYCLES;
                    m_fail = 0;
                end else begin
                    m_pulse = 1;
                    m_fail++;
                    if (m_fail == MAX_FAIL) m_lock = LOCK_CYCLES;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit kv, input int kd, input bit kc);
        exp_t e;
        rst = r; key_valid = kv; key_data = 4'(kd); key_clear = kc;
        model(r, kv, kd, kc);
        e.idx  = m_digits.size();
        e.unl  = (m_open > 0);
        e.fl   = m_pulse;
        e.alm  = (m_lock > 0);
        e.fcnt = m_fail;
        e.cb   = code_d[m_digits.size()];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic key(input int d);
        step(0, 1, d, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic good_code();
        for (int i = 0; i < DIGITS; i++) key(code_d[i]);
    endtask

    task automatic bad_code();
        key(2); key(0); key(2); key(6);
    endtask

    // Monitor: one expected record per clock edge, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("digit_idx", int'(digit_idx), e.idx);
                chk("unlock",    int'(unlock),    e.unl);
                chk("fail",      int'(fail),      e.fl);
                chk("alarm",     int'(alarm),     e.alm);
                chk("fail_cnt",  int'(fail_cnt),  e.fcnt);
                chk("cmp_b",     int'(cmp_b),     e.cb);
                chk("cmp_a",     int'(cmp_a),     int'(key_data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r, kd;
        #1;
        step(1, 0, 0, 0);
        // correct code, full open window
        good_code(); idle(OPEN_CYCLES + 2);
        // single wrong entry
        bad_code(); idle(2);
        // reach lockout, keys during alarm ignored
        bad_code(); bad_code();
        for (int i = 0; i < LOCK_CYCLES; i++) step(0, 1, code_d[i % DIGITS], i % 5 == 0);
        idle(2);
        good_code(); idle(OPEN_CYCLES + 1);
        // clear beats a simultaneous key
        key(2); key(0); step(0, 1, 2, 1); good_code(); idle(OPEN_CYCLES + 1);
        // two wrong, then right, then one wrong
        bad_code(); bad_code(); good_code(); idle(OPEN_CYCLES + 1);
        bad_code(); idle(2);
        // reset mid-OPEN and mid-LOCKOUT
        good_code(); idle(3); step(1, 0, 0, 0); idle(1);
        bad_code(); bad_code(); bad_code(); idle(5); step(1, 1, 2, 0); idle(1);
        // randomized traffic, biased toward the correct digits
        for (int n = 0; n < 2000; n++) begin
            r  = $urandom_range(0, 99);
            kd = ($urandom_range(0, 3) != 0) ? code_d[m_digits.size()] : int'($urandom_range(0, 15));
            if (r < 2)       step(1, $urandom_range(0, 1), kd, 0);
            else if (r < 6)  step(0, $urandom_range(0, 1), kd, 1);
            else if (r < 60) step(0, 1, kd, 0);
            else             step(0, 0, kd, 0);
        end
        idle(1);
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
